pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the go/clear pair of every stage buffer (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable.
- Resolves, in one cycle, load-use stalls, taken-branch flushes, memory wait states and syscall halt/resume.
- Keeps cycle, stall and flush statistics counters for the debug display.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 21 ++
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM encoding, default register-number width and the halt syscall code.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int REG_W_DEF = 5;
  localparam int HALT_CODE = 10;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hardwired and never hazards.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_memread,
  output logic             stall
);

  always_comb begin
    stall = ex_memread && (ex_rw != '0) &&
            ((id_rs_used && (id_rs == ex_rw)) ||
             (id_rt_used && (id_rt == ex_rw)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller: drives go/clear of every stage
// buffer and the PC, tracks halt/memory-wait state and debug statistics.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             wb_syscall,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             id_ex_go,
  output logic             ex_mem_go,
  output logic             mem_wb_go,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     state, state_nxt;
  logic       load_use;
  logic [4:0] go_c;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [3:0] clr_c;  // {if_id, id_ex, ex_mem, mem_wb}
  logic       stall_inc, flush_inc;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_rw      (ex_rw),
    .ex_memread (ex_memread),
    .stall      (load_use)
  );

  always_comb begin
    state_nxt = state;
    go_c      = 5'b00000;
    clr_c     = 4'b0000;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      // MEMWAIT with memory released resolves exactly like RUN.
      RUN, MEMWAIT: begin
        state_nxt = RUN;
        if (wb_syscall && wb_halt) begin
          go_c      = 5'b00001;
          clr_c     = 4'b0001;
          state_nxt = HALTED;
        end else if (mem_busy) begin
          state_nxt = MEMWAIT;
          stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          go_c      = 5'b11111;
          clr_c     = 4'b1100;
          flush_inc = 1'b1;
        end else if (load_use) begin
          go_c      = 5'b00111;
          clr_c     = 4'b0100;
          stall_inc = 1'b1;
        end else begin
          go_c = 5'b11111;
        end
      end
      HALTED: begin
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Reset forces bubbles into every buffer without waiting for a clock.
  always_comb begin
    {pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go} = rst_n ? go_c : 5'b00000;
    {if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear} = rst_n ? clr_c : 4'b1111;
    halted = (state == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != HALTED) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_inc)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc)       flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed go/clear vectors,
// halt/resume sequencing and statistics counter values.
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rw = '0;
  logic             id_rs_used = 0, id_rt_used = 0, ex_memread = 0;
  logic             ex_branch_taken = 0, mem_busy = 0;
  logic             wb_syscall = 0, wb_halt = 0, resume = 0;
  logic             pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go;
  logic             if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cyc = 0;
  int v0;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rw(ex_rw), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .wb_syscall(wb_syscall), .wb_halt(wb_halt), .resume(resume),
    .pc_go(pc_go), .if_id_go(if_id_go), .id_ex_go(id_ex_go),
    .ex_mem_go(ex_mem_go), .mem_wb_go(mem_wb_go),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
    .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [4:0] go_v  = {pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go};
  wire [3:0] clr_v = {if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear};

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the cycle counter model advances unless frozen.
  task automatic step(input bit frozen);
    @(posedge clk);
    #1;
    if (!frozen) exp_cyc++;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rw = '0;
    id_rs_used = 0; id_rt_used = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_busy = 0;
    wb_syscall = 0; wb_halt = 0; resume = 0;
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect at once.
    #23 rst_n = 1'b0;
    #1;
    chk_vec("rst_go", 32'(go_v), 32'h00);
    chk_vec("rst_clr", 32'(clr_v), 32'hF);
    chk_vec("rst_cyc", cycle_cnt, 0);
    chk_vec("rst_stall", stall_cnt, 0);
    chk_vec("rst_flush", flush_cnt, 0);
    chk_vec("rst_halted", 32'(halted), 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    exp_cyc = 0;
    chk_vec("rel_go", 32'(go_v), 32'h1F);
    chk_vec("rel_clr", 32'(clr_v), 32'h0);
    step(0);
    chk_vec("norm_cyc", cycle_cnt, 32'(exp_cyc));

    // Load-use on rs
    ex_memread = 1; ex_rw = 8; id_rs = 8; id_rs_used = 1;
    #1;
    chk_vec("lu_go", 32'(go_v), 32'h07);
    chk_vec("lu_clr", 32'(clr_v), 32'h4);
    step(0);
    chk_vec("lu_stall", stall_cnt, 1);

    // Destination r0 never hazards
    ex_rw = 0; id_rs = 0;
    #1;
    chk_vec("r0_go", 32'(go_v), 32'h1F);
    chk_vec("r0_clr", 32'(clr_v), 32'h0);
    step(0);
    chk_vec("r0_stall", stall_cnt, 1);

    // rs matches but is unused; rt matches and is used
    ex_rw = 5; id_rs = 5; id_rs_used = 0; id_rt = 9; id_rt_used = 1;
    #1;
    chk_vec("unused_go", 32'(go_v), 32'h1F);
    id_rt = 5;
    #1;
    chk_vec("lu_rt_go", 32'(go_v), 32'h07);
    step(0);
    chk_vec("lu_rt_stall", stall_cnt, 2);

    // Branch wins over simultaneous load-use
    ex_branch_taken = 1;
    #1;
    chk_vec("br_go", 32'(go_v), 32'h1F);
    chk_vec("br_clr", 32'(clr_v), 32'hC);
    step(0);
    chk_vec("br_flush", flush_cnt, 1);
    chk_vec("br_stall", stall_cnt, 2);

    // Memory wait with a branch held across it, serviced once on release
    clear_inputs();
    ex_branch_taken = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_vec($sformatf("mw_go%0d", i), 32'(go_v), 32'h00);
      chk_vec($sformatf("mw_clr%0d", i), 32'(clr_v), 32'h0);
      step(0);
    end
    chk_vec("mw_stall", stall_cnt, 5);
    chk_vec("mw_flush", flush_cnt, 1);
    mem_busy = 0;
    #1;
    chk_vec("mw_rel_go", 32'(go_v), 32'h1F);
    chk_vec("mw_rel_clr", 32'(clr_v), 32'hC);
    step(0);
    chk_vec("mw_rel_flush", flush_cnt, 2);
    chk_vec("mw_rel_stall", stall_cnt, 5);
    ex_branch_taken = 0;
    #1;
    chk_vec("mw_run_go", 32'(go_v), 32'h1F);
    step(0);

    // Halt syscall retires, then pipeline freezes
    v0 = 10;
    wb_syscall = 1; wb_halt = (v0 == HALT_CODE);
    #1;
    chk_vec("halt_go", 32'(go_v), 32'h01);
    chk_vec("halt_clr", 32'(clr_v), 32'h1);
    step(0);
    chk_vec("halted", 32'(halted), 1);
    chk_vec("halt_cyc", cycle_cnt, 32'(exp_cyc));
    mem_busy = 1; ex_branch_taken = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_vec($sformatf("hf_go%0d", i), 32'(go_v), 32'h00);
      step(1);
    end
    chk_vec("hf_cyc", cycle_cnt, 32'(exp_cyc));
    chk_vec("hf_stall", stall_cnt, 5);
    chk_vec("hf_flush", flush_cnt, 2);
    clear_inputs();
    resume = 1;
    #1;
    chk_vec("res_go", 32'(go_v), 32'h00);
    chk_vec("res_halted", 32'(halted), 1);
    step(1);
    resume = 0;
    #1;
    chk_vec("res_run", 32'(halted), 0);
    chk_vec("res_go2", 32'(go_v), 32'h1F);
    step(0);
    chk_vec("res_cyc", cycle_cnt, 32'(exp_cyc));

    // Non-halt syscall is a normal cycle
    v0 = 4;
    wb_syscall = 1; wb_halt = (v0 == HALT_CODE);
    #1;
    chk_vec("sys_go", 32'(go_v), 32'h1F);
    chk_vec("sys_clr", 32'(clr_v), 32'h0);
    step(0);
    chk_vec("sys_halted", 32'(halted), 0);

    // Reset while halted returns to RUN immediately
    wb_halt = 1;
    step(0);
    chk_vec("h2_halted", 32'(halted), 1);
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk_vec("rst2_halted", 32'(halted), 0);
    chk_vec("rst2_go", 32'(go_v), 32'h00);
    chk_vec("rst2_clr", 32'(clr_v), 32'hF);
    chk_vec("rst2_cyc", cycle_cnt, 0);
    #1 rst_n = 1'b1;
    #1;
    chk_vec("rst2_rel_go", 32'(go_v), 32'h1F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
